// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> HI/LO controller bundle: command, MFHI/MFLO read and status signals.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mf_req;
    logic             mf_sel;
    logic [WIDTH-1:0] hilo_rd_data;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, mf_req, mf_sel,
        input  hilo_rd_data, busy, stall, done, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, mf_req, mf_sel,
        output hilo_rd_data, busy, stall, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencing controller: iterative unsigned multiply / restoring divide,
// MTHI/MTLO writes and EX-stage stall arbitration.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic [WIDTH-1:0] acc_hi_r, acc_hi_s;
    logic [WIDTH-1:0] acc_lo_r, acc_lo_s;
    logic [WIDTH-1:0] opnd_r, opnd_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             is_div_r, is_div_s;
    logic             dbz_r, dbz_s;
    logic             busy_r, done_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH+1:0] div_diff_s;
    logic             div_neg_s;

    // One iteration of the datapath. Multiply keeps {acc_hi, acc_lo} as the
    // partial product with the multiplier draining out of acc_lo; divide keeps
    // the remainder in acc_hi and shifts quotient bits into acc_lo.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} +
                      (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
        div_neg_s   = div_diff_s[WIDTH+1];
    end

    // Next-state and next-register computation for the controller.
    always_comb begin
        state_s  = state_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        acc_hi_s = acc_hi_r;
        acc_lo_s = acc_lo_r;
        opnd_s   = opnd_r;
        cnt_s    = cnt_r;
        is_div_s = is_div_r;
        dbz_s    = dbz_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op[1] == 1'b0) begin
                        state_s  = ST_RUN;
                        cnt_s    = {CNT_W{1'b0}};
                        is_div_s = (bus.op == OP_DIVU);
                        dbz_s    = (bus.op == OP_DIVU) && (bus.operand_b == {WIDTH{1'b0}});
                        acc_hi_s = {WIDTH{1'b0}};
                        if (bus.op == OP_DIVU) begin
                            acc_lo_s = bus.operand_a;
                            opnd_s   = bus.operand_b;
                        end else begin
                            acc_lo_s = bus.operand_b;
                            opnd_s   = bus.operand_a;
                        end
                    end else if (bus.op == OP_MTHI) begin
                        hi_s = bus.operand_a;
                    end else begin
                        lo_s = bus.operand_a;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (is_div_r) begin
                    acc_hi_s = div_neg_s ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
                    acc_lo_s = {acc_lo_r[WIDTH-2:0], ~div_neg_s};
                end else begin
                    acc_hi_s = mul_sum_s[WIDTH:1];
                    acc_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
                end
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_WRITE: begin
                hi_s    = acc_hi_r;
                lo_s    = acc_lo_r;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, architectural HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            dbz_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            acc_hi_r <= acc_hi_s;
            acc_lo_r <= acc_lo_s;
            opnd_r   <= opnd_s;
            cnt_r    <= cnt_s;
            is_div_r <= is_div_s;
            dbz_r    <= dbz_s;
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= (state_s == ST_WRITE);
        end
    end

    // Reads come straight from HI/LO so an MT write in the same cycle is not forwarded.
    assign bus.hilo_rd_data = bus.mf_sel ? hi_r : lo_r;
    assign bus.stall        = busy_r & (bus.mf_req | bus.start);
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.div_by_zero  = dbz_r;
endmodule
